// File: rtl/decode_regfile.sv
// decode_regfile: RV32I register file with write-through bypass and pending-write scoreboard
module decode_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            IssueValid,
  input  logic [AW-1:0]   IssueRd,
  output logic            Busy1,
  output logic            Busy2
);
  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic             w_wr, w_iss, w_hit1, w_hit2;
  assign w_wr   = RegWriteW && RdW != '0;
  assign w_iss  = IssueValid && IssueRd != '0;
  assign w_hit1 = RegWriteW && RdW == A1;
  assign w_hit2 = RegWriteW && RdW == A2;
  // the issue update comes last so a same-edge set beats the retiring clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_regs <= '{default: '0};
      r_busy <= '0;
    end else begin
      if (w_wr) begin
        r_regs[RdW] <= ResultW;
        r_busy[RdW] <= 1'b0;
      end
      if (w_iss) r_busy[IssueRd] <= 1'b1;
    end
  end
  always_comb begin
    RD1   = A1 == '0 ? '0 : w_hit1 ? ResultW : r_regs[A1];
    RD2   = A2 == '0 ? '0 : w_hit2 ? ResultW : r_regs[A2];
    Busy1 = A1 != '0 && r_busy[A1] && !w_hit1;
    Busy2 = A2 != '0 && r_busy[A2] && !w_hit2;
  end
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: vector table plus write/readback sweep, checked through an expectation queue
module tb_decode_regfile;
  logic        clk = 0;
  logic        rst, RegWriteW, IssueValid, Busy1, Busy2;
  logic [4:0]  A1, A2, RdW, IssueRd;
  logic [31:0] RD1, RD2, ResultW;

  decode_regfile dut (
    .clk(clk), .rst(rst), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .IssueValid(IssueValid), .IssueRd(IssueRd), .Busy1(Busy1), .Busy2(Busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  a1, a2;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        iv;
    logic [4:0]  ird;
    logic        chk;
    logic [31:0] e1, e2;
    logic        eb1, eb2;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] e1, e2;
    logic        eb1, eb2;
  } exp_t;

  vec_t        vecs [$];
  exp_t        sb [$];
  int          compared = 0, mismatched = 0;
  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one cycle: drive on the falling edge, compare combinational outputs before the rising edge
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst = v.rst; A1 = v.a1; A2 = v.a2; RegWriteW = v.we; RdW = v.rd;
    ResultW = v.res; IssueValid = v.iv; IssueRd = v.ird;
    if (v.chk) sb.push_back('{tag, v.e1, v.e2, v.eb1, v.eb2});
    #2;
    if (v.chk) begin
      if (sb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL %s: scoreboard empty, got 1 entry expected", tag);
      end else begin
        e = sb.pop_front();
        check({e.tag, ".RD1"}, RD1, e.e1);
        check({e.tag, ".RD2"}, RD2, e.e2);
        check({e.tag, ".Busy1"}, {31'd0, Busy1}, {31'd0, e.eb1});
        check({e.tag, ".Busy2"}, {31'd0, Busy2}, {31'd0, e.eb2});
      end
    end
  endtask

  initial begin
    vec_t v;
    //                rst a1  a2  we rd  res            iv ird chk e1            e2            b1 b2
    vecs.push_back('{0, 5,  31, 1, 5,  32'hFFFFFFFF, 1, 5,  0, 0,            0,            0, 0});
    vecs.push_back('{1, 5,  31, 0, 0,  0,            0, 0,  1, 0,            0,            0, 0});
    vecs.push_back('{1, 7,  0,  1, 7,  32'hDEADBEEF, 0, 0,  1, 32'hDEADBEEF, 0,            0, 0});
    vecs.push_back('{1, 7,  5,  0, 0,  0,            0, 0,  1, 32'hDEADBEEF, 0,            0, 0});
    vecs.push_back('{1, 0,  0,  1, 0,  32'h12345678, 1, 0,  1, 0,            0,            0, 0});
    vecs.push_back('{1, 0,  7,  0, 0,  0,            0, 0,  1, 0,            32'hDEADBEEF, 0, 0});
    vecs.push_back('{1, 1,  2,  1, 3,  32'h11,       0, 0,  1, 0,            0,            0, 0});
    vecs.push_back('{1, 3,  3,  1, 3,  32'h22,       0, 0,  1, 32'h22,       32'h22,       0, 0});
    vecs.push_back('{1, 3,  3,  0, 0,  0,            0, 0,  1, 32'h22,       32'h22,       0, 0});
    vecs.push_back('{1, 9,  9,  0, 0,  0,            1, 9,  1, 0,            0,            0, 0});
    vecs.push_back('{1, 9,  9,  0, 0,  0,            0, 0,  1, 0,            0,            1, 1});
    vecs.push_back('{1, 0,  9,  1, 9,  32'hAB,       0, 0,  1, 0,            32'hAB,       0, 0});
    vecs.push_back('{1, 9,  9,  0, 0,  0,            0, 0,  1, 32'hAB,       32'hAB,       0, 0});
    vecs.push_back('{1, 4,  3,  0, 0,  0,            1, 4,  1, 0,            32'h22,       0, 0});
    vecs.push_back('{1, 4,  4,  1, 4,  32'h55,       1, 4,  1, 32'h55,       32'h55,       0, 0});
    vecs.push_back('{1, 4,  4,  0, 0,  0,            0, 0,  1, 32'h55,       32'h55,       1, 1});
    vecs.push_back('{1, 4,  6,  1, 6,  32'h66,       1, 10, 1, 32'h55,       32'h66,       1, 0});
    vecs.push_back('{0, 4,  10, 0, 0,  0,            1, 12, 1, 32'h55,       0,            1, 1});
    vecs.push_back('{1, 4,  12, 0, 0,  0,            0, 0,  1, 0,            0,            0, 0});
    vecs.push_back('{1, 7,  3,  0, 0,  0,            0, 0,  1, 0,            0,            0, 0});
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // sweep: fill every register, then read all of them back on both ports
    model[0] = 0;
    for (int i = 1; i < 32; i++) begin
      model[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      v = '{1, 5'(i), 0, 1, 5'(i), model[i], 0, 0, 1, model[i], 0, 0, 0};
      apply(v, $sformatf("wr%0d", i));
    end
    for (int i = 0; i < 32; i++) begin
      v = '{1, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 1, model[i], model[31 - i], 0, 0};
      apply(v, $sformatf("rd%0d", i));
    end
    if (sb.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL sb_drain: got %0d leftover expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Architectural integer register file for the 5-stage RV32I pipeline; the read-side counterpart of the writeback stage.
- Writeback drives the single write port (ResultW, RdW, RegWriteW). Decode reads two source operands combinationally, with write-through bypass so a same-cycle writeback is visible.
- Carries a per-register pending-write scoreboard, set at issue and cleared at writeback, so hazard logic can stall on outstanding long-latency writes.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (x0..x31); address width is log2(NREGS) = 5.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- A1  input  5  source register 1 address (rs1, decode stage).
- A2  input  5  source register 2 address (rs2, decode stage).
- RD1  output  XLEN  read data for A1, combinational.
- RD2  output  XLEN  read data for A2, combinational.
- RegWriteW  input  1  writeback write enable.
- RdW  input  5  writeback destination register.
- ResultW  input  XLEN  writeback data.
- IssueValid  input  1  decode issues an instruction that will write IssueRd.
- IssueRd  input  5  destination of issued instruction.
- Busy1  output  1  A1 has an outstanding write not yet retired, combinational.
- Busy2  output  1  A2 has an outstanding write not yet retired, combinational.

Behaviour:
- Reset
  - rst==0 at a rising edge clears all registers to 0 and all busy bits to 0.
  - Write and issue inputs are ignored in that cycle.
  - In the cycle after reset, RD1/RD2 = 0 and Busy1/Busy2 = 0 for any address.
- Write
  - On a rising edge with rst==1, RegWriteW==1 and RdW!=0: reg[RdW] <= ResultW.
  - Writes to x0 are dropped.
- Read (combinational, zero latency)
  - RDn = 0 if An==0.
  - Otherwise RDn = ResultW if RegWriteW==1 and RdW==An (write-through bypass, same cycle).
  - Otherwise RDn = reg[An].
  - Both ports are independent; A1==A2 returns identical data.
- Scoreboard (busy[1..31]; busy[0] is constant 0)
  - At the rising edge with rst==1:
    - IssueValid==1 and IssueRd!=0 sets busy[IssueRd].
    - RegWriteW==1 and RdW!=0 clears busy[RdW].
  - Simultaneous set and clear of the same register: set wins (the newer issue is still outstanding).
  - Clear of a register that is not busy: no effect, no error.
- Busy output
  - Busyn = busy[An] and not (RegWriteW==1 and RdW==An), i.e. the bypass also masks busy in the retiring cycle.
  - Busyn = 0 when An==0.
- No internal pipelining; no multi-cycle state machine; no backpressure.
- Reset mid-operation discards any pending writes and busy bits.

Test Plan:
- Reset then read: rst=0 for 1 edge, release; A1=5, A2=31 -> RD1=0, RD2=0, Busy1=Busy2=0.
- Basic write/read: RegWriteW=1, RdW=7, ResultW=0xDEADBEEF, clock; next cycle A1=7 -> RD1=0xDEADBEEF.
- x0 protection: write RdW=0, ResultW=0x12345678 and issue IssueRd=0 -> A1=0 gives RD1=0, Busy1=0.
- Bypass: reg[3]=0x11; same cycle RegWriteW=1, RdW=3, ResultW=0x22, A1=A2=3 -> RD1=RD2=0x22 before the edge, and 0x22 persists after it.
- Scoreboard: IssueValid=1, IssueRd=9, clock -> A2=9 gives Busy2=1. Then RegWriteW=1, RdW=9, ResultW=0xAB -> Busy2=0 and RD2=0xAB in that cycle; busy cleared after the edge.
- Set/clear collision and mid-op reset: busy[4]=1; same edge IssueRd=4 issue plus RdW=4 write -> Busy1(A1=4)=1 afterwards. Then rst=0 one edge -> Busy1=0, RD1=0.
